// File: rtl/ttl_pkg.sv
// Shared helpers for the TTL counter-family models (74x161/163/191).
// The MODULUS range check is a macro so each model expands it in its own generate scope.
`ifndef TTL_PKG_SV
`define TTL_PKG_SV

`define TTL_CHECK_MODULUS(width, modulus) \
  if ((modulus) < 2 || longint'(modulus) > (longint'(1) << (width))) begin : g_illegal_modulus \
    $error("ttl counter: MODULUS=%0d outside legal range 2..2**WIDTH (WIDTH=%0d)", modulus, width); \
  end

package ttl_pkg;

  localparam int TTL_QW = 32;

  // Callers zero-extend q; out-of-range q (>= modulus) can never match.
  function automatic logic ttl_is_terminal(input logic [TTL_QW-1:0] q,
                                           input logic [TTL_QW-1:0] modulus);
    return q == (modulus - TTL_QW'(1));
  endfunction

endpackage

`endif

// File: rtl/ttl74x163_counter.sv
// SN74x163/162 synchronous counter: sync reset/clear, parallel load, ENP/ENT enables,
// combinational ripple-carry. Pins keep datasheet names and polarities.
module ttl74x163_counter
  import ttl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR_n,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  `TTL_CHECK_MODULUS(WIDTH, MODULUS)

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_terminal;

  assign at_terminal = ttl_is_terminal(TTL_QW'(count_q), TTL_QW'(MODULUS));

  // NOTE: count_d gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (!CLR_n) begin
      count_d = '0;
    end else if (!LOAD_n) begin
      count_d = D;
    end else if (ENP && ENT) begin
      // Loaded values past the terminal count simply wrap through 2**WIDTH.
      count_d = at_terminal ? '0 : count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q   = count_q;
  assign RCO = ENT && at_terminal;

endmodule
